// File: rtl/udp_tx_packetizer.sv
// Store-and-forward UDP framer: buffers one datagram, counts its length,
// then emits a UDP header followed by the buffered payload.
module udp_tx_packetizer #(
  parameter int MAX_PAYLOAD = 1472,
  parameter int ADDR_WIDTH  = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic        s_tuser,
  input  logic [31:0] cfg_dest_ip,
  input  logic [15:0] cfg_source_port,
  input  logic [15:0] cfg_dest_port,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] drop_count,
  output logic [15:0] split_count
);

  typedef enum logic [1:0] {FILL, HDR, SEND} state_t;

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [15:0] LAST_IDX = 16'(MAX_PAYLOAD - 1);

  logic [7:0]  ram [0:DEPTH-1];
  logic [7:0]  ram_q;
  state_t      state;
  logic [15:0] count;
  logic [15:0] len;
  logic [15:0] rd_ptr;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic        q_valid;
  logic        q_last;
  logic        in_fire;
  logic        hdr_fire;
  logic        out_fire;
  logic        load;
  logic        move;

  assign in_fire  = s_tvalid & s_tready;
  assign hdr_fire = m_udp_hdr_valid & m_udp_hdr_ready;
  assign out_fire = m_tvalid & m_tready;
  assign load     = ~m_tvalid | out_fire;
  assign move     = q_valid & load;
  assign m_tuser  = 1'b0;

  // Prefetch: read the next byte whenever the read stage will be free.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = rd_ptr;
    if (hdr_fire) begin
      rd_en   = 1'b1;
      rd_addr = '0;
    end else if (state == SEND && rd_ptr < len
                 && (!q_valid || move)) begin
      rd_en = 1'b1;
    end
  end

  // Payload buffer: write on accepted input, registered read.
  always_ff @(posedge clk) begin
    if (in_fire)
      ram[count[ADDR_WIDTH-1:0]] <= s_tdata;
    if (rd_en)
      ram_q <= ram[rd_addr[ADDR_WIDTH-1:0]];
  end

  // Framing FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= FILL;
      count             <= '0;
      len               <= '0;
      rd_ptr            <= '0;
      q_valid           <= 1'b0;
      q_last            <= 1'b0;
      s_tready          <= 1'b0;
      m_udp_hdr_valid   <= 1'b0;
      m_udp_ip_dest_ip  <= '0;
      m_udp_source_port <= '0;
      m_udp_dest_port   <= '0;
      m_udp_length      <= '0;
      m_tdata           <= '0;
      m_tvalid          <= 1'b0;
      m_tlast           <= 1'b0;
      drop_count        <= '0;
      split_count       <= '0;
    end else begin
      case (state)
        FILL: begin
          s_tready <= 1'b1;
          if (in_fire) begin
            if (count == '0) begin
              m_udp_ip_dest_ip  <= cfg_dest_ip;
              m_udp_source_port <= cfg_source_port;
              m_udp_dest_port   <= cfg_dest_port;
            end
            if (s_tlast && s_tuser) begin
              count <= '0;
              if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            end else if (s_tlast || count == LAST_IDX) begin
              if (!s_tlast && split_count != 16'hFFFF)
                split_count <= split_count + 16'd1;
              len             <= count + 16'd1;
              m_udp_length    <= count + 16'd9;
              s_tready        <= 1'b0;
              m_udp_hdr_valid <= 1'b1;
              state           <= HDR;
            end else begin
              count <= count + 16'd1;
            end
          end
        end
        HDR: begin
          if (hdr_fire) begin
            m_udp_hdr_valid <= 1'b0;
            state           <= SEND;
          end
        end
        SEND: begin
          if (out_fire && m_tlast) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            count    <= '0;
            s_tready <= 1'b1;
            state    <= FILL;
          end else if (load) begin
            m_tvalid <= q_valid;
            if (q_valid) begin
              m_tdata <= ram_q;
              m_tlast <= q_last;
            end
          end
        end
        default: state <= FILL;
      endcase
      if (rd_en) begin
        rd_ptr  <= rd_addr + 16'd1;
        q_valid <= 1'b1;
        q_last  <= (rd_addr == len - 16'd1);
      end else if (move) begin
        q_valid <= 1'b0;
      end
    end
  end

endmodule
